// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the converter sequencer: code/result widths, the
// sequencer state encoding, the operating-mode encoding and a helper that
// sizes the settle/dwell counters.
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int CODE_W = 3;
    localparam int RES_W  = 5;

    // Highest code reached by a sweep.
    localparam logic [CODE_W-1:0] CODE_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CAPTURE,
        DWELL
    } conv_seq_state_t;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_SWEEP  = 1'b1
    } conv_mode_t;

    // Bits needed to hold 0..limit; never less than one bit so a zero-length
    // phase still produces a legal vector.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/conv_dwell_timer.sv
// -----------------------------------------------------------------------------
// conv_dwell_timer
// Phase timer used for both the settle and the dwell interval. While `count`
// is high the internal counter advances once per clock; `expire` flags the
// last clock of a LIMIT-clock phase so the FSM can leave on that edge.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   load    in   clear the counter (held while the phase is not active)
//   count   in   advance the counter
//   expire  out  high during the final clock of the phase
// -----------------------------------------------------------------------------
module conv_dwell_timer import conv_pkg::*; #(
    parameter int LIMIT = 4,
    parameter int CNT_W = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);

    // A zero-length phase is never entered by the FSM; treating it as
    // expiring immediately keeps the timer from ever stalling.
    localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// conv_seq_ctrl
// Sequences codes into an external combinational converter, waits for it to
// settle, captures its output and either finishes (single mode) or holds the
// result for a dwell interval and steps to the next code (sweep 0..7).
//
// Build option: define CONV_SEQ_REPEAT_EN for a continuous sweep that wraps
// 7->0 with a done pulse per lap; a start during a sweep then stops it at the
// end of the current dwell.
//
// Ports:
//   CLOCK_50     in   sole clock
//   reset        in   asynchronous active-high reset
//   start        in   operation request, honoured only in IDLE
//   mode         in   0 = single conversion of code_in, 1 = sweep
//   code_in      in   code for single mode
//   conv_in      out  code presented to the converter
//   conv_result  in   converter output for conv_in
//   result       out  last captured conv_result
//   code_out     out  code that produced result
//   busy         out  high whenever not IDLE
//   done         out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module conv_seq_ctrl import conv_pkg::*; #(
    parameter int DWELL_CYCLES  = 50000000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [CODE_W-1:0] code_in,
    output logic [CODE_W-1:0] conv_in,
    input  logic [RES_W-1:0]  conv_result,
    output logic [RES_W-1:0]  result,
    output logic [CODE_W-1:0] code_out,
    output logic              busy,
    output logic              done
);

    conv_seq_state_t   state;
    conv_mode_t        mode_q;
    logic [CODE_W-1:0] code_q;
    logic              settle_exp;
    logic              dwell_exp;
`ifdef CONV_SEQ_REPEAT_EN
    logic              stop_q;
`endif

    // Each timer runs only in its own state and is held clear otherwise, so
    // it restarts from zero on every entry.
    conv_dwell_timer #(.LIMIT(SETTLE_CYCLES)) u_settle (
        .clk    (CLOCK_50),
        .rst    (reset),
        .load   (state != SETTLE),
        .count  (state == SETTLE),
        .expire (settle_exp)
    );

    conv_dwell_timer #(.LIMIT(DWELL_CYCLES)) u_dwell (
        .clk    (CLOCK_50),
        .rst    (reset),
        .load   (state != DWELL),
        .count  (state == DWELL),
        .expire (dwell_exp)
    );

    // The code register is itself the converter drive, so conv_in is a
    // registered output that holds through every state.
    assign conv_in = code_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mode_q   <= MODE_SINGLE;
            code_q   <= '0;
            result   <= '0;
            code_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef CONV_SEQ_REPEAT_EN
            stop_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= conv_mode_t'(mode);
                        code_q <= mode ? '0 : code_in;
                        busy   <= 1'b1;
                        state  <= DRIVE;
`ifdef CONV_SEQ_REPEAT_EN
                        stop_q <= 1'b0;
`endif
                    end
                end

                DRIVE: begin
                    state <= (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
                end

                SETTLE: begin
                    if (settle_exp) begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    result   <= conv_result;
                    code_out <= code_q;
                    if (mode_q == MODE_SWEEP) begin
                        state <= DWELL;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                DWELL: begin
                    if (dwell_exp) begin
`ifdef CONV_SEQ_REPEAT_EN
                        if (stop_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            // Wrap is the only place the code may roll over.
                            if (code_q == CODE_MAX) begin
                                done <= 1'b1;
                            end
                            code_q <= code_q + CODE_W'(1);
                            state  <= DRIVE;
                        end
`else
                        if (code_q == CODE_MAX) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            code_q <= code_q + CODE_W'(1);
                            state  <= DRIVE;
                        end
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

`ifdef CONV_SEQ_REPEAT_EN
            // A start seen during a sweep is remembered until the dwell ends.
            if (state != IDLE && mode_q == MODE_SWEEP && start) begin
                stop_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_seq_ctrl
// Bench for conv_seq_ctrl. A behavioural converter with one clock of input
// lag sits on conv_in/conv_result. Expected timing is computed from the
// operation length: each code occupies DRIVE + settle + CAPTURE (+ dwell in
// sweep), so with the start cycle numbered 0 the done pulse appears in cycle
// 1 + codes * period. A second instance with no settle time checks the short
// latency path. Compile with CONV_SEQ_REPEAT_EN to cover the wrapping sweep.
// -----------------------------------------------------------------------------
module tb_conv_seq_ctrl;

    localparam int S = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [2:0] code_in;

    logic [2:0] conv_in,  conv_in_d;
    logic [4:0] conv_result, result;
    logic [2:0] code_out;
    logic       busy, done;

    logic [2:0] conv_in0, conv_in0_d;
    logic [4:0] conv_result0, result0;
    logic [2:0] code_out0;
    logic       busy0, done0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Reference converter: inverter, adder, then a one-hot decode folded in.
    function automatic logic [4:0] conv_model(input logic [2:0] c);
        logic [4:0] r;
        r = {2'b00, ~c} + 5'd5;
        r = r ^ (5'd1 << c[1:0]);
        return r;
    endfunction

    // The converter output follows its input one clock late, so a capture
    // that skips the settle/drive phases sees a stale value.
    always @(posedge clk) begin
        conv_in_d  <= conv_in;
        conv_in0_d <= conv_in0;
    end
    assign conv_result  = conv_model(conv_in_d);
    assign conv_result0 = conv_model(conv_in0_d);

    conv_seq_ctrl #(.DWELL_CYCLES(D), .SETTLE_CYCLES(S)) dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .start       (start),
        .mode        (mode),
        .code_in     (code_in),
        .conv_in     (conv_in),
        .conv_result (conv_result),
        .result      (result),
        .code_out    (code_out),
        .busy        (busy),
        .done        (done)
    );

    conv_seq_ctrl #(.DWELL_CYCLES(D), .SETTLE_CYCLES(0)) dut0 (
        .CLOCK_50    (clk),
        .reset       (rst),
        .start       (start),
        .mode        (mode),
        .code_in     (code_in),
        .conv_in     (conv_in0),
        .conv_result (conv_result0),
        .result      (result0),
        .code_out    (code_out0),
        .busy        (busy0),
        .done        (done0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete operation on dut. poke > 0 raises start again in that
    // cycle; it must be ignored.
    task automatic run_op(input string tag, input logic m, input logic [2:0] c, input int poke);
        int n_codes, per, t_done, first_done, dones, conv_errs, busy_errs, k;
        logic [2:0] exp_code;
        n_codes    = m ? 8 : 1;
        per        = S + 2 + (m ? D : 0);
        t_done     = 1 + n_codes * per;
        first_done = -1;
        dones      = 0;
        conv_errs  = 0;
        busy_errs  = 0;
        mode = m; code_in = c; start = 1'b1;
        tick();
        // Scramble the inputs: the operation must run from latched values.
        mode = ~m; code_in = ~c; start = 1'b0;
        for (int cyc = 1; cyc <= t_done + 2; cyc++) begin
            k = (cyc - 1) / per;
            if (k > n_codes - 1) k = n_codes - 1;
            exp_code = m ? 3'(k) : c;
            if (conv_in !== exp_code) conv_errs++;
            if (busy !== logic'(cyc < t_done)) busy_errs++;
            if (cyc == 1 + k * per + S + 2) begin
                check({tag, " code_out"}, 32'(code_out), 32'(exp_code));
                check({tag, " result"}, 32'(result), 32'(conv_model(exp_code)));
            end
            if (done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = cyc;
            end
            start = (cyc == poke);
            if (cyc == poke) code_in = 3'($urandom);
            tick();
        end
        start = 1'b0;
        check({tag, " done cycle"}, first_done, t_done);
        check({tag, " done count"}, dones, 1);
        check({tag, " conv_in track"}, conv_errs, 0);
        check({tag, " busy track"}, busy_errs, 0);
    endtask

`ifdef CONV_SEQ_REPEAT_EN
    // Sweep through one wrap, then stop it from the dwell of code 2 in lap 2.
    task automatic run_repeat();
        int per, t_wrap, t_poke, t_stop, k, errs;
        int done_t[$];
        per    = S + 2 + D;
        t_wrap = 1 + 8 * per;
        t_poke = 1 + 10 * per + S + 2;
        t_stop = 1 + 11 * per;
        errs   = 0;
        mode = 1'b1; code_in = 3'($urandom); start = 1'b1;
        tick();
        mode = 1'b0; start = 1'b0;
        for (int cyc = 1; cyc <= t_stop + 2; cyc++) begin
            k = (cyc - 1) / per;
            if (k > 10) k = 10;
            if (conv_in !== 3'(k % 8)) errs++;
            if (busy !== logic'(cyc < t_stop)) errs++;
            if (cyc == 1 + k * per + S + 2 &&
                (code_out !== 3'(k % 8) || result !== conv_model(3'(k % 8)))) errs++;
            if (done === 1'b1) done_t.push_back(cyc);
            start = (cyc == t_poke);
            tick();
        end
        start = 1'b0;
        check("repeat track", errs, 0);
        check("repeat done count", done_t.size(), 2);
        check("repeat wrap done", (done_t.size() > 0) ? done_t[0] : -1, t_wrap);
        check("repeat stop done", (done_t.size() > 1) ? done_t[1] : -1, t_stop);
        check("repeat code_out", 32'(code_out), 2);
        check("repeat busy", 32'(busy), 0);
    endtask
`endif

    initial begin
        int  d_main, d_zero, dones, found;
        logic rm;

        rst = 1'b1; start = 1'b0; mode = 1'b0; code_in = 3'd0;
        tick();
        tick();
        check("in reset busy", 32'(busy), 0);
        check("in reset conv_in", 32'(conv_in), 0);
        rst = 1'b0;
        tick();
        tick();
        check("idle conv_in", 32'(conv_in), 0);
        check("idle result", 32'(result), 0);
        check("idle code_out", 32'(code_out), 0);
        check("idle busy", 32'(busy), 0);
        check("idle done", 32'(done), 0);

        // Zero settle time: done 3 cycles after start, versus S+3 on dut.
        d_main = -1; d_zero = -1;
        mode = 1'b0; code_in = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= S + 6; cyc++) begin
            if (done0 === 1'b1 && d_zero < 0) d_zero = cyc;
            if (done === 1'b1 && d_main < 0) d_main = cyc;
            tick();
        end
        check("nosettle done cycle", d_zero, 3);
        check("nosettle result", 32'(result0), 32'(conv_model(3'd1)));
        check("nosettle code_out", 32'(code_out0), 1);
        check("settle done cycle", d_main, S + 3);

        run_op("single5", 1'b0, 3'd5, -1);
        run_op("ignore", 1'b0, 3'd3, 2);

`ifdef CONV_SEQ_REPEAT_EN
        run_repeat();
`else
        run_op("sweep", 1'b1, 3'd0, -1);
`endif

        // Start held high: first done at S+3, restart visible the next cycle.
        d_main = -1;
        mode = 1'b0; code_in = 3'd2; start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= S + 5; cyc++) begin
            if (done === 1'b1 && d_main < 0) d_main = cyc;
            if (cyc == S + 4) check("held start restart busy", 32'(busy), 1);
            tick();
        end
        start = 1'b0;
        check("held start done cycle", d_main, S + 3);
        repeat (S + 6) tick();
        check("held start settles idle", 32'(busy), 0);

        // Reset in the middle of a sweep at code 4.
        found = 0;
        mode = 1'b1; code_in = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (conv_in === 3'd4) found = 1;
            else tick();
        end
        check("reset reach code4", found, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst conv_in", 32'(conv_in), 0);
        check("async rst result", 32'(result), 0);
        check("async rst code_out", 32'(code_out), 0);
        check("async rst busy", 32'(busy), 0);
        check("async rst done", 32'(done), 0);
        dones = 0;
        repeat (3) begin
            tick();
            if (done === 1'b1) dones++;
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("reset no done", dones, 0);
        check("reset idle busy", 32'(busy), 0);
        run_op("post reset single6", 1'b0, 3'd6, -1);

        for (int i = 0; i < 6; i++) begin
`ifdef CONV_SEQ_REPEAT_EN
            rm = 1'b0;
`else
            rm = ($urandom_range(0, 3) == 0);
`endif
            run_op($sformatf("rand%0d", i), rm, 3'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000000; clocks each swept result is held (1 s at 50 MHz).
REQ-002 Parameter SETTLE_CYCLES, default 2; clocks allowed for the combinational converter to settle before capture.
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 mode  in  1  0 = single conversion of code_in, 1 = sweep codes 0..7; sampled with start.
REQ-007 code_in  in  3  code converted in single mode.
REQ-008 conv_in  out  3  code driven to the converter (inverter/adder/decoder chain).
REQ-009 conv_result  in  5  converter output for conv_in.
REQ-010 result  out  5  last captured conv_result.
REQ-011 code_out  out  3  code that produced result.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse when an operation completes.

Function
REQ-014 States SHALL be IDLE, DRIVE, SETTLE, CAPTURE, DWELL.
REQ-015 IDLE: start=1 SHALL latch mode, load the code register (code_in if mode=0, 3'd0 if mode=1), go to DRIVE next cycle.
REQ-016 DRIVE: conv_in SHALL equal the code register; state SHALL go to SETTLE after one cycle.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES clocks, then go to CAPTURE; SETTLE_CYCLES=0 goes directly DRIVE->CAPTURE.
REQ-018 CAPTURE: result<=conv_result and code_out<=code register, in one cycle.
REQ-019 After CAPTURE in single mode: done=1 for one cycle, return to IDLE; start-to-done latency = SETTLE_CYCLES+3 clocks.
REQ-020 After CAPTURE in sweep mode: enter DWELL for exactly DWELL_CYCLES clocks.
REQ-021 DWELL end with code<7: code increments by 1, go to DRIVE.
REQ-022 DWELL end with code=7: done=1 for one cycle, return to IDLE (no repeat build).
REQ-023 conv_in SHALL hold the code register in all states; it SHALL be 0 in IDLE after reset until first start.
REQ-024 start while busy SHALL be ignored, not queued; start held high SHALL restart only after IDLE is reached, one cycle after done.
REQ-025 Code arithmetic is 3-bit unsigned; increment never wraps except via REQ-031.
REQ-026 Dwell counter width SHALL be ceil(log2(DWELL_CYCLES+1)); counter clears on every DWELL entry.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, conv_in=0, result=0, code_out=0, busy=0, done=0, all counters 0, independent of clock.
REQ-028 Reset mid-operation SHALL abandon the operation with no done pulse; the first start after release is honoured.

Configuration
REQ-029 Macro CONV_SEQ_REPEAT_EN selects continuous sweep.
REQ-030 Without it: REQ-022 behaviour.
REQ-031 With it: at DWELL end with code=7, code wraps to 0 and sweep continues with done pulsed each wrap; start=1 during any sweep state SHALL stop the sweep at the next DWELL end (done pulse, IDLE); single mode unchanged.

Structure
REQ-032 Shared package conv_pkg SHALL hold CODE_W=3, RES_W=5 and the state enum conv_seq_state_t.
REQ-033 Dwell/settle counting SHALL be a sub-module conv_dwell_timer (load, count, expire outputs); FSM remains in conv_seq_ctrl.

Verification
REQ-034 Single: mode=0, code_in=3'b101, start one cycle, SETTLE_CYCLES=2 -> conv_in=5 from next cycle, done at cycle 5, code_out=5, result=model(5).
REQ-035 Sweep: mode=1, DWELL_CYCLES=4 -> conv_in steps 0..7, result/code_out update once per code, exactly one done after code 7, busy low next cycle.
REQ-036 Start ignored: pulse start at cycle 2 of a single conversion with code_in=3 -> no second operation, exactly one done.
REQ-037 Reset mid-sweep at code 4 -> all outputs 0 asynchronously, no done; new single start of code 6 completes normally.
REQ-038 CONV_SEQ_REPEAT_EN defined, DWELL_CYCLES=4 -> code goes 7->0 with done pulse; start during DWELL of code 2 -> stop after that DWELL, IDLE, code_out=2.
REQ-039 SETTLE_CYCLES=0 single of code 1 -> done 3 clocks after start.
